// File: rtl/riscv_core_icache_pkg.sv
// rtl/riscv_core_icache_pkg.sv - shared types and constants for the I-cache refill engine
package riscv_core_icache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_AR    = 3'd1,
        ST_R     = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } refill_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         LINE_OFFSET_W  = 5;

endpackage

// File: rtl/riscv_core_icache_axi_refill.sv
// rtl/riscv_core_icache_axi_refill.sv - I-cache line refill over one AXI4 INCR read burst
// Optional R-phase watchdog with drain state: ICACHE_REFILL_TIMEOUT_EN
module riscv_core_icache_axi_refill
    import riscv_core_icache_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int LINE_WIDTH     = 256,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ID         = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_mem_req,
    input  logic [ADDR_WIDTH-1:0]     i_addr,
    output logic                      o_mem_done,
    output logic [LINE_WIDTH-1:0]     o_line,
    output logic                      o_err,
    output logic                      o_arvalid,
    input  logic                      i_arready,
    output logic [ADDR_WIDTH-1:0]     o_araddr,
    output logic [AXI_ID_WIDTH-1:0]   o_arid,
    output logic [7:0]                o_arlen,
    output logic [2:0]                o_arsize,
    output logic [1:0]                o_arburst,
    input  logic                      i_rvalid,
    output logic                      o_rready,
    input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]                i_rresp,
    input  logic                      i_rlast
);

    localparam int BEATS = LINE_WIDTH / AXI_DATA_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    refill_state_e    r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    logic w_resp_bad;
    logic w_last_beat;
    logic w_unused;

    assign w_resp_bad  = (i_rresp != AXI_RESP_OKAY);
    assign w_last_beat = (r_cnt == LAST_BEAT);
    assign w_unused    = ^{i_addr[LINE_OFFSET_W-1:0], (TIMEOUT_CYCLES > 0)};

    assign o_arid    = AXI_ID_WIDTH'(AXI_ID);
    assign o_arlen   = 8'(BEATS - 1);
    assign o_arsize  = 3'($clog2(AXI_DATA_WIDTH / 8));
    assign o_arburst = AXI_BURST_INCR;

`ifdef ICACHE_REFILL_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDOG_W-1:0] r_wdog;
    logic              r_timed_out;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            o_mem_done <= 1'b0;
            o_err      <= 1'b0;
            o_arvalid  <= 1'b0;
            o_rready   <= 1'b0;
            o_araddr   <= '0;
            o_line     <= '0;
`ifdef ICACHE_REFILL_TIMEOUT_EN
            r_wdog      <= '0;
            r_timed_out <= 1'b0;
`endif
        end else begin
            o_mem_done <= 1'b0;
            o_err      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_mem_req) begin
                        o_araddr  <= {i_addr[ADDR_WIDTH-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
                        r_err     <= 1'b0;
                        o_arvalid <= 1'b1;
                        r_state   <= ST_AR;
                    end
                end
                // ARVALID stays up until accepted; AXI forbids withdrawing it
                ST_AR: begin
                    if (i_arready) begin
                        o_arvalid <= 1'b0;
                        o_rready  <= 1'b1;
                        r_cnt     <= '0;
`ifdef ICACHE_REFILL_TIMEOUT_EN
                        r_wdog    <= '0;
`endif
                        r_state   <= ST_R;
                    end
                end
                ST_R: begin
                    if (i_rvalid) begin
                        o_line[int'(r_cnt)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= i_rdata;
`ifdef ICACHE_REFILL_TIMEOUT_EN
                        r_wdog <= '0;
`endif
                        // The burst length is fixed by the counter, not by RLAST
                        if (w_last_beat) begin
                            o_rready   <= 1'b0;
                            o_mem_done <= 1'b1;
                            o_err      <= r_err | w_resp_bad | ~i_rlast;
                            r_state    <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            r_err <= r_err | w_resp_bad | i_rlast;
                        end
                    end
`ifdef ICACHE_REFILL_TIMEOUT_EN
                    else if (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
                        o_rready    <= 1'b0;
                        o_mem_done  <= 1'b1;
                        o_err       <= 1'b1;
                        r_timed_out <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
`ifdef ICACHE_REFILL_TIMEOUT_EN
                    if (r_timed_out) begin
                        r_timed_out <= 1'b0;
                        o_rready    <= 1'b1;
                        r_state     <= ST_DRAIN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
`else
                    r_state <= ST_IDLE;
`endif
                end
`ifdef ICACHE_REFILL_TIMEOUT_EN
                // Late beats of the abandoned burst are swallowed so the next burst starts clean
                ST_DRAIN: begin
                    if (i_rvalid && i_rlast) begin
                        o_rready <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    o_arvalid <= 1'b0;
                    o_rready  <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
